// File: rtl/sha256_multiblock_engine.sv
// Iterative SHA-256 compression engine, one round per clock, with chaining
// between pre-padded 512-bit blocks and a one-cycle digest-valid pulse.
module sha256_multiblock_engine #(
    parameter int                   WRD_SIZE  = 32,
    parameter int                   MSG_SIZ   = 512,
    parameter int                   HASH_SIZE = 256,
    parameter int                   ROUNDS    = 64,
    parameter int                   CNT_SIZE  = 6,
    parameter logic [HASH_SIZE-1:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    input  logic [MSG_SIZ-1:0]   i_msg,
    input  logic                 i_first,
    input  logic                 i_last,
    output logic                 o_busy,
    output logic [CNT_SIZE-1:0]  o_round,
    output logic [HASH_SIZE-1:0] o_digest,
    output logic                 o_digest_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

    localparam logic [CNT_SIZE-1:0] LAST_RND = CNT_SIZE'(ROUNDS - 1);

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t                        r_state, w_state_nxt;
    logic [0:7][WRD_SIZE-1:0]      r_h;        // chaining value H0..H7
    logic [0:7][WRD_SIZE-1:0]      r_v;        // working variables a..h
    logic [0:15][WRD_SIZE-1:0]     r_w;        // schedule window, W[0] is the current round word
    logic [CNT_SIZE-1:0]           r_cnt;
    logic                          r_last;
    logic [HASH_SIZE-1:0]          r_digest;
    logic                          r_dvalid;

    logic [5:0]                    w_kidx;
    logic [WRD_SIZE-1:0]           w_t1, w_t2, w_wnew;
    logic [0:7][WRD_SIZE-1:0]      w_hsum;
    logic [HASH_SIZE-1:0]          w_chain;

    always_comb begin
        w_kidx = 6'(r_cnt);
        w_t1   = r_v[7]
               + (f_rotr(r_v[4], 6) ^ f_rotr(r_v[4], 11) ^ f_rotr(r_v[4], 25))
               + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
               + K[w_kidx] + r_w[0];
        w_t2   = (f_rotr(r_v[0], 2) ^ f_rotr(r_v[0], 13) ^ f_rotr(r_v[0], 22))
               + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        w_wnew = (f_rotr(r_w[14], 17) ^ f_rotr(r_w[14], 19) ^ (r_w[14] >> 10))
               + r_w[9]
               + (f_rotr(r_w[1], 7) ^ f_rotr(r_w[1], 18) ^ (r_w[1] >> 3))
               + r_w[0];
        w_hsum = '0;
        for (int i = 0; i < 8; i++) begin
            w_hsum[i] = r_h[i] + r_v[i];
        end
        // A first block restarts from IV and drops any unfinished chain.
        w_chain = i_first ? IV : r_h;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_blk_ready = 1'b0;
        o_busy      = 1'b0;
        o_round     = '0;
        case (r_state)
            S_IDLE: begin
                o_blk_ready = 1'b1;
                if (i_blk_valid) w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                o_busy  = 1'b1;
                o_round = r_cnt;
                if (r_cnt == LAST_RND) w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                o_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h      <= IV;
            r_v      <= '0;
            r_w      <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_digest <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_blk_valid) begin
                        r_v    <= w_chain;
                        r_h    <= w_chain;
                        r_w    <= i_msg;
                        r_last <= i_last;
                        r_cnt  <= '0;
                    end
                end
                S_ROUND: begin
                    r_v   <= {w_t1 + w_t2, r_v[0], r_v[1], r_v[2], r_v[3] + w_t1, r_v[4], r_v[5], r_v[6]};
                    r_w   <= {r_w[1:15], w_wnew};
                    r_cnt <= (r_cnt == LAST_RND) ? '0 : r_cnt + 1'b1;
                end
                S_UPDATE: begin
                    r_h <= w_hsum;
                    if (r_last) begin
                        r_digest <= w_hsum;
                        r_dvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_digest       = r_digest;
    assign o_digest_valid = r_dvalid;

endmodule

// File: tb/tb_sha256_multiblock_engine.sv
// Bench for sha256_multiblock_engine: known-answer table, handshake corner
// sequences, and random multi-block messages against a plain SHA-256 model.
module tb_sha256_multiblock_engine;

    localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_B2  = {480'h0, 32'h000001c0};

    localparam logic [0:63][31:0] TK = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         i_blk_valid = 1'b0;
    logic [511:0] i_msg = '0;
    logic         i_first = 1'b0;
    logic         i_last = 1'b0;
    logic         o_blk_ready, o_busy, o_digest_valid;
    logic [5:0]   o_round;
    logic [255:0] o_digest;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] model_h;

    sha256_multiblock_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_blk_valid    (i_blk_valid),
        .o_blk_ready    (o_blk_ready),
        .i_msg          (i_msg),
        .i_first        (i_first),
        .i_last         (i_last),
        .o_busy         (o_busy),
        .o_round        (o_round),
        .o_digest       (o_digest),
        .o_digest_valid (o_digest_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[r] + w[r];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_blk_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_h = IV;
    endtask

    // Present one block, then watch until the engine is idle again.
    task automatic run_block(input logic [511:0] m, input logic f, input logic l,
                             output logic got, output logic [255:0] dig, output int lat);
        bit done;
        done = 0; got = 0; dig = '0; lat = 0;
        @(negedge clk);
        i_msg = m; i_first = f; i_last = l; i_blk_valid = 1'b1;
        @(posedge clk);
        #1 i_blk_valid = 1'b0;
        for (int n = 1; n <= 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (o_digest_valid) begin got = 1; dig = o_digest; lat = n; end
            if (o_blk_ready) done = 1;
        end
        if (!done) chk("block_timeout", 0, 1);
    endtask

    typedef struct {
        logic [511:0] msg;
        logic         first;
        logic         last;
        logic         pulse;
        logic [255:0] exp;
    } vec_t;

    initial begin
        vec_t         tv [5];
        logic         got;
        logic [255:0] dig, held;
        int           lat, cyc, lowrun;
        int           pulses [$];
        int           runs [$];
        logic [255:0] digs [$];

        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready", o_blk_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_round", o_round, 0);
        chk("rst_digest", o_digest, 0);
        chk("rst_valid", o_digest_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_h = IV;

        // Known answers, including chaining and an abandoned chain.
        tv[0] = '{M_ABC, 1'b1, 1'b1, 1'b1, D_ABC};
        tv[1] = '{M_B1,  1'b1, 1'b0, 1'b0, '0};
        tv[2] = '{M_B2,  1'b0, 1'b1, 1'b1, D_TWO};
        tv[3] = '{M_B1,  1'b1, 1'b0, 1'b0, '0};
        tv[4] = '{M_ABC, 1'b1, 1'b1, 1'b1, D_ABC};
        held = '0;
        for (int i = 0; i < 5; i++) begin
            run_block(tv[i].msg, tv[i].first, tv[i].last, got, dig, lat);
            chk($sformatf("tv%0d_pulse", i), got, tv[i].pulse);
            if (tv[i].pulse) begin
                chk($sformatf("tv%0d_digest", i), dig, tv[i].exp);
                chk($sformatf("tv%0d_latency", i), lat, 65);
                held = tv[i].exp;
                @(posedge clk);
                #1 chk($sformatf("tv%0d_pulse_width", i), o_digest_valid, 0);
            end else begin
                chk($sformatf("tv%0d_digest_hold", i), o_digest, held);
            end
        end

        // Back-to-back accepts with i_blk_valid held high.
        do_reset();
        i_msg = M_ABC; i_first = 1'b1; i_last = 1'b1; i_blk_valid = 1'b1;
        cyc = 0; lowrun = 0;
        for (int n = 0; n < 300 && pulses.size() < 2; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_digest_valid) begin pulses.push_back(cyc); digs.push_back(o_digest); end
            if (!o_blk_ready) lowrun++;
            else begin
                if (lowrun > 0) runs.push_back(lowrun);
                lowrun = 0;
            end
        end
        i_blk_valid = 1'b0;
        chk("b2b_pulse_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("b2b_gap", pulses[1] - pulses[0], 66);
            chk("b2b_digest0", digs[0], D_ABC);
            chk("b2b_digest1", digs[1], D_ABC);
        end
        chk("b2b_ready_low", (runs.size() > 0) ? runs[0] : 0, 65);
        repeat (70) @(posedge clk);

        // Reset at round 30; afterwards H must be IV even with i_first=0.
        @(negedge clk);
        i_msg = M_ABC; i_first = 1'b1; i_last = 1'b1; i_blk_valid = 1'b1;
        @(posedge clk);
        #1 i_blk_valid = 1'b0;
        for (int n = 0; n < 100 && o_round != 6'd30; n++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_reached_r30", o_round, 30);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", o_busy, 0);
        chk("mid_ready", o_blk_ready, 1);
        chk("mid_digest", o_digest, 0);
        chk("mid_round", o_round, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_h = IV;
        run_block(M_ABC, 1'b0, 1'b1, got, dig, lat);
        chk("post_reset_pulse", got, 1);
        chk("post_reset_digest", dig, D_ABC);

        // Inputs thrash during ROUND; result and round index must be unaffected.
        @(negedge clk);
        i_msg = M_ABC; i_first = 1'b1; i_last = 1'b1; i_blk_valid = 1'b1;
        @(posedge clk);
        #1 chk("stall_round0", o_round, 0);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            i_blk_valid = 1'($urandom);
            i_first = 1'($urandom);
            i_last = 1'($urandom);
            for (int j = 0; j < 16; j++) i_msg[511 - 32*j -: 32] = $urandom;
            @(posedge clk);
            #1 chk($sformatf("stall_round%0d", k), o_round, (k < 64) ? k : 0);
        end
        @(negedge clk);
        i_blk_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_pulse", o_digest_valid, 1);
        chk("stall_digest", o_digest, D_ABC);

        // Random multi-block messages; some continue the previous chain.
        do_reset();
        for (int m = 0; m < 6; m++) begin
            int   nb;
            logic f;
            logic [511:0] blk;
            nb = $urandom_range(1, 3);
            f  = ($urandom_range(0, 3) != 0);
            if (f) model_h = IV;
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = $urandom;
                run_block(blk, (b == 0) ? f : 1'b0, (b == nb - 1), got, dig, lat);
                model_h = compress(model_h, blk);
                chk($sformatf("rnd%0d_blk%0d_pulse", m, b), got, (b == nb - 1));
                if (b == nb - 1) chk($sformatf("rnd%0d_digest", m), dig, model_h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
